// File: rtl/control_unit_fsm.sv
// Control FSM for the 8-bit accumulator CPU: fetch/decode/execute sequencing, outputs decoded combinationally.
// Latency: 3 clocks per instruction; backpressure: INPUT holds (InWait) until Enter is high, HALT holds until reset.
module control_unit_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Enter,
  input  logic [2:0]         i_IR,
  input  logic               i_Aeq0,
  input  logic               i_Apos,
  output logic               o_IRload,
  output logic               o_PCload,
  output logic               o_JMPmux,
  output logic               o_Meminst,
  output logic               o_MemWr,
  output logic               o_Aload,
  output logic               o_Sub,
  output logic [1:0]         o_Asel,
  output logic               o_InWait,
  output logic               o_Halt,
  output logic [STATE_W-1:0] o_State
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  state_t r_state;
  state_t w_next;

  logic       w_IRload;
  logic       w_PCload;
  logic       w_JMPmux;
  logic       w_Meminst;
  logic       w_MemWr;
  logic       w_Aload;
  logic       w_Sub;
  logic [1:0] w_Asel;
  logic       w_InWait;
  logic       w_Halt;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = S_START;
    w_IRload  = 1'b0;
    w_PCload  = 1'b0;
    w_JMPmux  = 1'b0;
    w_Meminst = 1'b0;
    w_MemWr   = 1'b0;
    w_Aload   = 1'b0;
    w_Sub     = 1'b0;
    w_Asel    = ASEL_ALU;
    w_InWait  = 1'b0;
    w_Halt    = 1'b0;
    case (r_state)
      S_START: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_IRload = 1'b1;
        w_PCload = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        w_Meminst = 1'b1;
        case (i_IR)
          OP_LOAD:  w_next = S_LOAD;
          OP_STORE: w_next = S_STORE;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_INPUT: w_next = S_INPUT;
          OP_JZ:    w_next = S_JZ;
          OP_JPOS:  w_next = S_JPOS;
          default:  w_next = S_HALT;
        endcase
      end
      S_LOAD: begin
        w_Meminst = 1'b1;
        w_Asel    = ASEL_RAM;
        w_Aload   = 1'b1;
        w_next    = S_FETCH;
      end
      S_STORE: begin
        w_Meminst = 1'b1;
        w_MemWr   = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADD: begin
        w_Meminst = 1'b1;
        w_Aload   = 1'b1;
        w_next    = S_FETCH;
      end
      S_SUB: begin
        w_Meminst = 1'b1;
        w_Sub     = 1'b1;
        w_Aload   = 1'b1;
        w_next    = S_FETCH;
      end
      S_INPUT: begin
        w_Asel   = ASEL_IN;
        w_InWait = 1'b1;
        w_Aload  = i_Enter;
        w_next   = i_Enter ? S_FETCH : S_INPUT;
      end
      // Not-taken branches leave PC alone: it was already advanced in FETCH.
      S_JZ: begin
        w_JMPmux = 1'b1;
        w_PCload = i_Aeq0;
        w_next   = S_FETCH;
      end
      S_JPOS: begin
        w_JMPmux = 1'b1;
        w_PCload = i_Apos;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_Halt = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_START;
      end
    endcase
  end

  // Gating on the raw reset kills any write/load pulse the instant reset falls.
  assign o_IRload  = w_IRload  & i_Reset;
  assign o_PCload  = w_PCload  & i_Reset;
  assign o_JMPmux  = w_JMPmux  & i_Reset;
  assign o_Meminst = w_Meminst & i_Reset;
  assign o_MemWr   = w_MemWr   & i_Reset;
  assign o_Aload   = w_Aload   & i_Reset;
  assign o_Sub     = w_Sub     & i_Reset;
  assign o_Asel    = w_Asel    & {2{i_Reset}};
  assign o_InWait  = w_InWait  & i_Reset;
  assign o_Halt    = w_Halt    & i_Reset;
  assign o_State   = STATE_W'(r_state);

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: walks each opcode and checks state code and control word.
module tb_control_unit_fsm;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_Enter = 1'b0;
  logic [2:0] i_IR    = 3'b000;
  logic       i_Aeq0  = 1'b0;
  logic       i_Apos  = 1'b0;
  logic       o_IRload, o_PCload, o_JMPmux, o_Meminst, o_MemWr, o_Aload, o_Sub;
  logic [1:0] o_Asel;
  logic       o_InWait, o_Halt;
  logic [3:0] o_State;

  int n_chk  = 0;
  int n_fail = 0;

  control_unit_fsm #(.STATE_W(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Enter(i_Enter), .i_IR(i_IR),
    .i_Aeq0(i_Aeq0), .i_Apos(i_Apos),
    .o_IRload(o_IRload), .o_PCload(o_PCload), .o_JMPmux(o_JMPmux),
    .o_Meminst(o_Meminst), .o_MemWr(o_MemWr), .o_Aload(o_Aload), .o_Sub(o_Sub),
    .o_Asel(o_Asel), .o_InWait(o_InWait), .o_Halt(o_Halt), .o_State(o_State)
  );

  always #5 i_Clock = ~i_Clock;

  // Control word: {IRload,PCload,JMPmux,Meminst,MemWr,Aload,Sub,Asel[1:0],InWait,Halt}
  localparam logic [10:0] C_NONE   = 11'b00000000000;
  localparam logic [10:0] C_FETCH  = 11'b11000000000;
  localparam logic [10:0] C_DECODE = 11'b00010000000;
  localparam logic [10:0] C_LOAD   = 11'b00010101000;
  localparam logic [10:0] C_STORE  = 11'b00011000000;
  localparam logic [10:0] C_ADD    = 11'b00010100000;
  localparam logic [10:0] C_SUB    = 11'b00010110000;
  localparam logic [10:0] C_INWAIT = 11'b00000000110;
  localparam logic [10:0] C_INGO   = 11'b00000100110;
  localparam logic [10:0] C_JNT    = 11'b00100000000;
  localparam logic [10:0] C_JT     = 11'b01100000000;
  localparam logic [10:0] C_HALT   = 11'b00000000001;

  logic [10:0] w_ctl;
  assign w_ctl = {o_IRload, o_PCload, o_JMPmux, o_Meminst, o_MemWr, o_Aload,
                  o_Sub, o_Asel, o_InWait, o_Halt};

  task automatic chk(input string tag, input logic [3:0] exp_state, input logic [10:0] exp_ctl);
    n_chk++;
    assert (o_State === exp_state) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, o_State, exp_state);
    end
    n_chk++;
    assert (w_ctl === exp_ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, w_ctl, exp_ctl);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // Runs FETCH and DECODE for opcode op, leaving the FSM in the execute state.
  task automatic fetch_decode(input string tag, input logic [2:0] op);
    i_IR = op;
    tick(); chk({tag, "_fetch"}, 4'd1, C_FETCH);
    tick(); chk({tag, "_decode"}, 4'd2, C_DECODE);
    tick();
  endtask

  initial begin
    // Reset held, with inputs that would otherwise assert outputs
    i_IR = 3'b111; i_Enter = 1'b1; i_Aeq0 = 1'b1; i_Apos = 1'b1;
    #2;
    chk("reset_async", 4'd0, C_NONE);
    tick(); chk("reset_held", 4'd0, C_NONE);
    i_IR = 3'b000; i_Enter = 1'b0; i_Aeq0 = 1'b0; i_Apos = 1'b0;
    #2 i_Reset = 1'b1;
    #1 chk("start", 4'd0, C_NONE);

    // LOAD loop: 0,1,2,3,1,2,3
    for (int k = 0; k < 2; k++) begin
      fetch_decode("load", 3'b000);
      chk("load_exec", 4'd3, C_LOAD);
    end

    fetch_decode("sub", 3'b011);
    chk("sub_exec", 4'd6, C_SUB);
    fetch_decode("store", 3'b001);
    chk("store_exec", 4'd4, C_STORE);

    i_Aeq0 = 1'b0;
    fetch_decode("jz0", 3'b101);
    chk("jz_not_taken", 4'd8, C_JNT);
    i_Aeq0 = 1'b1;
    fetch_decode("jz1", 3'b101);
    chk("jz_taken", 4'd8, C_JT);
    i_Aeq0 = 1'b0;
    i_Apos = 1'b1;
    fetch_decode("jpos1", 3'b110);
    chk("jpos_taken", 4'd9, C_JT);
    i_Apos = 1'b0;
    fetch_decode("jpos0", 3'b110);
    chk("jpos_not_taken", 4'd9, C_JNT);

    // INPUT waits on Enter, then loads in the Enter cycle
    fetch_decode("input", 3'b100);
    for (int k = 0; k < 4; k++) begin
      chk("input_wait", 4'd7, C_INWAIT);
      tick();
    end
    chk("input_wait_last", 4'd7, C_INWAIT);
    i_Enter = 1'b1;
    #1 chk("input_enter", 4'd7, C_INGO);
    tick();
    i_Enter = 1'b0;
    #1 chk("input_to_fetch", 4'd1, C_FETCH);
    tick(); chk("input_next_decode", 4'd2, C_DECODE);

    // ADD aborted by an asynchronous reset pulse
    i_IR = 3'b010;
    tick(); chk("add_exec", 4'd5, C_ADD);
    #2 i_Reset = 1'b0;
    #1 chk("add_reset_cut", 4'd0, C_NONE);
    tick(); chk("add_reset_held", 4'd0, C_NONE);
    #3 i_Reset = 1'b1;
    #1 chk("restart_start", 4'd0, C_NONE);
    tick(); chk("restart_fetch", 4'd1, C_FETCH);
    tick(); chk("restart_decode", 4'd2, C_DECODE);
    tick(); chk("restart_add", 4'd5, C_ADD);

    // HALT is sticky regardless of Enter and IR
    fetch_decode("halt", 3'b111);
    chk("halt_enter", 4'd10, C_HALT);
    for (int k = 0; k < 20; k++) begin
      i_Enter = ~i_Enter;
      i_IR    = 3'($urandom_range(0, 7));
      tick();
      chk("halt_hold", 4'd10, C_HALT);
    end
    i_Enter = 1'b0;
    #2 i_Reset = 1'b0;
    #1 chk("halt_reset", 4'd0, C_NONE);
    #3 i_Reset = 1'b1;
    i_IR = 3'b000;
    #1 chk("halt_reset_release", 4'd0, C_NONE);
    tick(); chk("post_halt_fetch", 4'd1, C_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Control FSM for the 8-bit accumulator CPU; drives every control input of the general datapath and consumes its status outputs (IR opcode, Aeq0, Apos).
- Sequences fetch/decode/execute for the 3-bit opcode set and handshakes external input through Enter.
- Together with the datapath it forms the complete processor.

Parameters:
STATE_W, 4, width of the debug state output; must be >= 4.

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
Enter  input  1  operator input-valid strobe (level), used by INPUT
IR  input  3  opcode IR[7:5] from datapath
Aeq0  input  1  accumulator == 0
Apos  input  1  accumulator >= 0 (sign bit clear)
IRload  output  1  load instruction register
PCload  output  1  load PC
JMPmux  output  1  1 = PC source is IR[4:0], 0 = PC+1
Meminst  output  1  1 = RAM address from IR[4:0], 0 = from PC
MemWr  output  1  RAM write enable (A -> M[IR[4:0]])
Aload  output  1  load accumulator
Sub  output  1  1 = A - M, 0 = A + M
Asel  output  2  A source: 00 adder/subtractor, 01 data_in, 10 RAM, 11 unused (never driven)
InWait  output  1  high while waiting for Enter in INPUT
Halt  output  1  high in HALT
State  output  STATE_W  current state code (debug)

Behaviour:
- Reset low: State goes to START immediately (asynchronous). Every control output, InWait and Halt are 0 while Reset is low and in START.
- Only the state register is clocked. Outputs decode combinationally from state plus IR/Aeq0/Apos/Enter. Controls not listed for a state are 0.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- State codes: START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10. Codes 11-15 are illegal and go to START on the next clock with all outputs 0.
- START: no outputs asserted -> FETCH.
- FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. IR <= M[PC] and PC <= PC+1 at the same edge. -> DECODE.
- DECODE: Meminst=1 (operand address presented). IR is valid in this cycle. Branch on IR to the matching execute state.
- LOAD: Meminst=1, Asel=10, Aload=1 -> FETCH.
- STORE: Meminst=1, MemWr=1 -> FETCH.
- ADD: Meminst=1, Asel=00, Sub=0, Aload=1 -> FETCH.
- SUB: Meminst=1, Asel=00, Sub=1, Aload=1 -> FETCH.
- INPUT: Asel=01, InWait=1.
  - Enter=0: Aload=0, stay in INPUT.
  - Enter=1: Aload=1 in that cycle, -> FETCH. Enter is level-sensitive; it is sampled only in INPUT and ignored elsewhere.
- JZ: JMPmux=1, PCload=Aeq0 -> FETCH. Not taken leaves PC unchanged; PC already points to the next instruction.
- JPOS: JMPmux=1, PCload=Apos -> FETCH. A=0 counts as positive.
- HALT: Halt=1, all controls 0. Stays in HALT until Reset; Enter and IR are ignored.
- Latency: every instruction takes 3 clocks (FETCH, DECODE, execute), except INPUT (3 + Enter wait) and HALT (terminal). START is traversed only once after reset.
- Reset asserted mid-instruction aborts it. A MemWr/Aload pulse is cut off asynchronously, so no partial write occurs after Reset falls.
- No two of IRload, Aload, MemWr are ever high in the same cycle. PCload is only high in FETCH, JZ and JPOS.

Test Plan:
- Reset, then IR=000 held: State sequence 0,1,2,3,1,2,3...
  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0.
  - LOAD: Asel=10, Aload=1, Meminst=1.
  - All outputs 0 during reset.
- IR=011, then IR=001:
  - SUB cycle: Asel=00, Sub=1, Aload=1, Meminst=1.
  - STORE cycle: MemWr=1, Meminst=1, Aload=0.
  - Sub=0 in all other cycles.
- IR=101 with Aeq0=0: JZ cycle has JMPmux=1, PCload=0. Repeat with Aeq0=1: PCload=1. IR=110 with Apos=1: PCload=1; with Apos=0: PCload=0.
- IR=100, Enter=0 for 4 clocks: State stays 7, InWait=1, Asel=01, Aload=0. Enter=1: Aload=1 that cycle, next State=1.
- IR=111: Halt=1 and State=10 held for 20 clocks with Enter toggling and IR changing; all controls 0. Reset low then high: State=0, Halt=0.
- Reset pulsed low mid-ADD, asynchronous to Clock: Aload drops to 0 without waiting for an edge, State=0; after release the sequence restarts at START->FETCH.
